// File: rtl/noc_router.sv
// rtl/noc_router.sv - input-queued single-flit router, per-output round-robin arbitration
// Optional per-egress transfer counters (flit_cnt) when NOC_ROUTER_STATS_EN is defined.
module noc_router #(
  parameter int NUM_PORTS  = 5,
  parameter int PORT_WIDTH = 128,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                              clk,
  input  logic                              srst,
  input  logic [NUM_PORTS-1:0]              ing_val,
  input  logic [NUM_PORTS*PORT_WIDTH-1:0]   ing_dat,
  output logic [NUM_PORTS-1:0]              ing_rdy,
  output logic [NUM_PORTS-1:0]              egr_val,
  output logic [NUM_PORTS*PORT_WIDTH-1:0]   egr_dat,
  input  logic [NUM_PORTS-1:0]              egr_rdy,
  output logic                              drop_err
`ifdef NOC_ROUTER_STATS_EN
  , output logic [NUM_PORTS*32-1:0]         flit_cnt
`endif
);

  localparam int DEST_W = ($clog2(NUM_PORTS) > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int AW     = $clog2(FIFO_DEPTH);
  localparam int CW     = AW + 1;

  logic [PORT_WIDTH-1:0] mem_q     [NUM_PORTS][FIFO_DEPTH];
  logic [AW-1:0]         wptr_q    [NUM_PORTS];
  logic [AW-1:0]         rptr_q    [NUM_PORTS];
  logic [CW-1:0]         cnt_q     [NUM_PORTS];
  logic [CW-1:0]         cnt_d     [NUM_PORTS];
  logic [NUM_PORTS-1:0]  rdy_q;
  logic [DEST_W-1:0]     rr_q      [NUM_PORTS];
  logic [DEST_W-1:0]     rr_d      [NUM_PORTS];
  logic [NUM_PORTS-1:0]  egr_val_q;
  logic [PORT_WIDTH-1:0] egr_dat_q [NUM_PORTS];
  logic                  drop_err_q;

  logic [PORT_WIDTH-1:0] head      [NUM_PORTS];
  logic [DEST_W-1:0]     head_dest [NUM_PORTS];
  logic [NUM_PORTS-1:0]  nonempty, push, pop, drop, gnt_vld;
  logic [DEST_W-1:0]     gnt_idx   [NUM_PORTS];

  // rdy_q is the registered not-full flag; srst only masks it so ready drops during reset.
  assign ing_rdy = rdy_q & {NUM_PORTS{~srst}};

  always_comb begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      head[p]      = mem_q[p][rptr_q[p]];
      head_dest[p] = head[p][PORT_WIDTH-1 -: DEST_W];
      nonempty[p]  = (cnt_q[p] != '0);
      drop[p]      = nonempty[p] && (32'(head_dest[p]) >= NUM_PORTS);
      push[p]      = ing_val[p] & ing_rdy[p];
    end
  end

  always_comb begin : arb
    logic [DEST_W:0]   sum;
    logic [DEST_W-1:0] cand;
    sum  = '0;
    cand = '0;
    pop  = drop;
    for (int o = 0; o < NUM_PORTS; o++) begin
      gnt_vld[o] = 1'b0;
      gnt_idx[o] = '0;
      rr_d[o]    = rr_q[o];
      if (!egr_val_q[o] || egr_rdy[o]) begin
        for (int k = 0; k < NUM_PORTS; k++) begin
          sum = {1'b0, rr_q[o]} + (DEST_W+1)'(k);
          if (sum >= (DEST_W+1)'(NUM_PORTS)) sum = sum - (DEST_W+1)'(NUM_PORTS);
          cand = sum[DEST_W-1:0];
          if (!gnt_vld[o] && nonempty[cand] && !drop[cand] && head_dest[cand] == DEST_W'(o)) begin
            gnt_vld[o] = 1'b1;
            gnt_idx[o] = cand;
          end
        end
      end
      if (gnt_vld[o]) begin
        rr_d[o] = (gnt_idx[o] == DEST_W'(NUM_PORTS-1)) ? '0 : gnt_idx[o] + 1'b1;
        pop[gnt_idx[o]] = 1'b1;
      end
    end
    for (int p = 0; p < NUM_PORTS; p++) begin
      cnt_d[p] = cnt_q[p] + CW'(push[p]) - CW'(pop[p]);
    end
  end

  always_ff @(posedge clk) begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (push[p]) mem_q[p][wptr_q[p]] <= ing_dat[p*PORT_WIDTH +: PORT_WIDTH];
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        wptr_q[p]    <= '0;
        rptr_q[p]    <= '0;
        cnt_q[p]     <= '0;
        rr_q[p]      <= '0;
        egr_dat_q[p] <= '0;
      end
      rdy_q      <= '1;
      egr_val_q  <= '0;
      drop_err_q <= 1'b0;
    end else begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (push[p]) wptr_q[p] <= wptr_q[p] + 1'b1;
        if (pop[p])  rptr_q[p] <= rptr_q[p] + 1'b1;
        cnt_q[p] <= cnt_d[p];
        rdy_q[p] <= (cnt_d[p] < CW'(FIFO_DEPTH));
        rr_q[p]  <= rr_d[p];
        if (gnt_vld[p]) begin
          egr_val_q[p] <= 1'b1;
          egr_dat_q[p] <= head[gnt_idx[p]];
        end else if (egr_rdy[p]) begin
          egr_val_q[p] <= 1'b0;
        end
      end
      drop_err_q <= |drop;
    end
  end

  always_comb begin
    egr_dat = '0;
    for (int o = 0; o < NUM_PORTS; o++) egr_dat[o*PORT_WIDTH +: PORT_WIDTH] = egr_dat_q[o];
  end
  assign egr_val  = egr_val_q;
  assign drop_err = drop_err_q;

`ifdef NOC_ROUTER_STATS_EN
  logic [31:0] stat_q [NUM_PORTS];

  always_ff @(posedge clk) begin
    for (int o = 0; o < NUM_PORTS; o++) begin
      if (srst) stat_q[o] <= '0;
      else if (egr_val_q[o] && egr_rdy[o]) stat_q[o] <= stat_q[o] + 32'd1;
    end
  end

  always_comb begin
    flit_cnt = '0;
    for (int o = 0; o < NUM_PORTS; o++) flit_cnt[o*32 +: 32] = stat_q[o];
  end
`endif

endmodule
